// File: rtl/remote_req_sched.sv
// rtl/remote_req_sched.sv - remote request issue scheduler with credit limit and register scoreboard
module remote_req_sched #(
    parameter  int max_out_credits_p = 32,
    parameter  int num_reg_p         = 32,
    localparam int reg_id_width_lp   = $clog2(num_reg_p),
    localparam int credit_width_lp   = $clog2(max_out_credits_p + 1)
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,

    input  logic                       ifetch_v_i,
    output logic                       ifetch_ready_o,

    input  logic                       ld_v_i,
    input  logic                       ld_float_i,
    input  logic [reg_id_width_lp-1:0] ld_reg_id_i,
    output logic                       ld_ready_o,

    input  logic                       st_v_i,
    output logic                       st_ready_o,

    output logic                       out_v_o,
    output logic [2:0]                 out_sel_o,
    input  logic                       out_ready_i,

    input  logic                       returned_v_i,
    input  logic [1:0]                 returned_type_i,
    input  logic [reg_id_width_lp-1:0] returned_reg_id_i,
    output logic                       returned_yumi_o,

    output logic [credit_width_lp-1:0] credits_o,
    output logic [num_reg_p-1:0]       int_pending_o,
    output logic [num_reg_p-1:0]       float_pending_o,
    output logic                       ifetch_pending_o,
    output logic                       idle_o,
    output logic                       error_o
);

    typedef enum logic {
        rr_load_first_e  = 1'b0,
        rr_store_first_e = 1'b1
    } rr_e;

    localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_out_credits_p);

    logic [credit_width_lp-1:0] credits_r, credits_n;
    logic [num_reg_p-1:0]       int_pending_r, int_pending_n;
    logic [num_reg_p-1:0]       float_pending_r, float_pending_n;
    logic                       ifetch_pending_r, ifetch_pending_n;
    logic                       error_r, error_n;
    rr_e                        rr_r, rr_n;

    logic have_credit;
    logic at_max_credits;
    logic ld_hazard;
    logic ifetch_elig, ld_elig, st_elig;
    logic issue;
    logic ret_fire;

    // Eligibility and arbitration use only registered state; returns never bypass into hazard checks
    always_comb begin
        have_credit    = (credits_r != '0);
        at_max_credits = (credits_r == max_credits_lp);
        ld_hazard      = ld_float_i ? float_pending_r[ld_reg_id_i] : int_pending_r[ld_reg_id_i];

        ifetch_elig = reset_n_i & ifetch_v_i & ~ifetch_pending_r & have_credit;
        ld_elig     = reset_n_i & ld_v_i & have_credit & ~ld_hazard;
        st_elig     = reset_n_i & st_v_i & have_credit;

        out_sel_o = 3'b000;
        if (ifetch_elig) begin
            out_sel_o = 3'b001;
        end else if (ld_elig && st_elig) begin
            out_sel_o = (rr_r == rr_load_first_e) ? 3'b010 : 3'b100;
        end else if (ld_elig) begin
            out_sel_o = 3'b010;
        end else if (st_elig) begin
            out_sel_o = 3'b100;
        end

        out_v_o        = |out_sel_o;
        issue          = out_v_o & out_ready_i;
        ifetch_ready_o = out_sel_o[0] & issue;
        ld_ready_o     = out_sel_o[1] & issue;
        st_ready_o     = out_sel_o[2] & issue;

        returned_yumi_o = returned_v_i & reset_n_i;
        ret_fire        = returned_v_i & returned_yumi_o;
    end

    // Next-state for credits, scoreboards, error flag and round-robin pointer
    always_comb begin
        credits_n        = credits_r;
        int_pending_n    = int_pending_r;
        float_pending_n  = float_pending_r;
        ifetch_pending_n = ifetch_pending_r;
        error_n          = error_r;
        rr_n             = rr_r;

        // A return always frees a credit; one arriving with nothing outstanding is a protocol error
        if (ret_fire && at_max_credits) begin
            error_n = 1'b1;
        end
        if (issue && !ret_fire) begin
            credits_n = credits_r - credit_width_lp'(1);
        end else if (ret_fire && !issue && !at_max_credits) begin
            credits_n = credits_r + credit_width_lp'(1);
        end

        // Retire the matching scoreboard bit; a return for a clear bit flags an error
        if (ret_fire) begin
            case (returned_type_i)
                2'd0: begin
                    if (!int_pending_r[returned_reg_id_i]) error_n = 1'b1;
                    int_pending_n[returned_reg_id_i] = 1'b0;
                end
                2'd1: begin
                    if (!float_pending_r[returned_reg_id_i]) error_n = 1'b1;
                    float_pending_n[returned_reg_id_i] = 1'b0;
                end
                2'd2: begin
                    if (!ifetch_pending_r) error_n = 1'b1;
                    ifetch_pending_n = 1'b0;
                end
                default: begin
                end
            endcase
        end

        // Issue marks its destination pending; int reg 0 is hardwired zero and never tracked
        if (ld_ready_o) begin
            if (ld_float_i) begin
                float_pending_n[ld_reg_id_i] = 1'b1;
            end else if (ld_reg_id_i != '0) begin
                int_pending_n[ld_reg_id_i] = 1'b1;
            end
            rr_n = rr_store_first_e;
        end
        if (st_ready_o) begin
            rr_n = rr_load_first_e;
        end
        if (ifetch_ready_o) begin
            ifetch_pending_n = 1'b1;
        end
    end

    // State registers with synchronous active-low reset discarding all outstanding work
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            credits_r        <= max_credits_lp;
            int_pending_r    <= '0;
            float_pending_r  <= '0;
            ifetch_pending_r <= 1'b0;
            error_r          <= 1'b0;
            rr_r             <= rr_load_first_e;
        end else begin
            credits_r        <= credits_n;
            int_pending_r    <= int_pending_n;
            float_pending_r  <= float_pending_n;
            ifetch_pending_r <= ifetch_pending_n;
            error_r          <= error_n;
            rr_r             <= rr_n;
        end
    end

    assign credits_o        = credits_r;
    assign int_pending_o    = int_pending_r;
    assign float_pending_o  = float_pending_r;
    assign ifetch_pending_o = ifetch_pending_r;
    assign error_o          = error_r;
    assign idle_o           = at_max_credits & ~(|int_pending_r) & ~(|float_pending_r) & ~ifetch_pending_r;

endmodule

// File: tb/tb_remote_req_sched.sv
// tb/tb_remote_req_sched.sv - directed self-checking bench for remote_req_sched
module tb_remote_req_sched;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        ifetch_v_i;
    logic        ifetch_ready_o;
    logic        ld_v_i;
    logic        ld_float_i;
    logic [4:0]  ld_reg_id_i;
    logic        ld_ready_o;
    logic        st_v_i;
    logic        st_ready_o;
    logic        out_v_o;
    logic [2:0]  out_sel_o;
    logic        out_ready_i;
    logic        returned_v_i;
    logic [1:0]  returned_type_i;
    logic [4:0]  returned_reg_id_i;
    logic        returned_yumi_o;
    logic [5:0]  credits_o;
    logic [31:0] int_pending_o;
    logic [31:0] float_pending_o;
    logic        ifetch_pending_o;
    logic        idle_o;
    logic        error_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    remote_req_sched dut (
        .clk_i             (clk_i),
        .reset_n_i         (reset_n_i),
        .ifetch_v_i        (ifetch_v_i),
        .ifetch_ready_o    (ifetch_ready_o),
        .ld_v_i            (ld_v_i),
        .ld_float_i        (ld_float_i),
        .ld_reg_id_i       (ld_reg_id_i),
        .ld_ready_o        (ld_ready_o),
        .st_v_i            (st_v_i),
        .st_ready_o        (st_ready_o),
        .out_v_o           (out_v_o),
        .out_sel_o         (out_sel_o),
        .out_ready_i       (out_ready_i),
        .returned_v_i      (returned_v_i),
        .returned_type_i   (returned_type_i),
        .returned_reg_id_i (returned_reg_id_i),
        .returned_yumi_o   (returned_yumi_o),
        .credits_o         (credits_o),
        .int_pending_o     (int_pending_o),
        .float_pending_o   (float_pending_o),
        .ifetch_pending_o  (ifetch_pending_o),
        .idle_o            (idle_o),
        .error_o           (error_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk_i);
    endtask

    task automatic ret(input logic v, input logic [1:0] t, input logic [4:0] r);
        returned_v_i      = v;
        returned_type_i   = t;
        returned_reg_id_i = r;
    endtask

    initial begin
        reset_n_i   = 1'b0;
        ifetch_v_i  = 1'b0;
        ld_v_i      = 1'b1;
        ld_float_i  = 1'b0;
        ld_reg_id_i = 5'd5;
        st_v_i      = 1'b0;
        out_ready_i = 1'b1;
        ret(1'b0, 2'd0, 5'd0);
        repeat (2) @(posedge clk_i);
        next_cycle();
        #1;
        chk("rst_out_v", out_v_o, 0);
        chk("rst_ld_ready", ld_ready_o, 0);
        chk("rst_credits", credits_o, 32);
        chk("rst_idle", idle_o, 1);
        chk("rst_error", error_o, 0);

        // First int load to reg 5
        reset_n_i = 1'b1;
        #1;
        chk("ld5_sel", out_sel_o, 3'b010);
        chk("ld5_ready", ld_ready_o, 1);
        next_cycle();
        #1;
        chk("ld5_credits", credits_o, 31);
        chk("ld5_pending", int_pending_o[5], 1);
        chk("ld5_idle", idle_o, 0);
        chk("ld5_hazard_out_v", out_v_o, 0);
        ret(1'b1, 2'd0, 5'd5);
        #1;
        chk("ret5_yumi", returned_yumi_o, 1);
        chk("ret5_no_bypass", out_v_o, 0);
        next_cycle();
        ret(1'b0, 2'd0, 5'd0);
        #1;
        chk("ret5_cleared", int_pending_o[5], 0);
        chk("ret5_credits", credits_o, 32);
        chk("ld5_reissue", ld_ready_o, 1);
        next_cycle();
        // Store alone flips pointer back to load-first; return reg 5 in parallel
        ld_v_i = 1'b0;
        st_v_i = 1'b1;
        ret(1'b1, 2'd0, 5'd5);
        #1;
        chk("st_sel", out_sel_o, 3'b100);
        chk("st_ready", st_ready_o, 1);
        next_cycle();
        st_v_i = 1'b0;
        ret(1'b1, 2'd3, 5'd0);
        #1;
        chk("st_ret_credits", credits_o, 31);
        chk("st_ret_int_clear", int_pending_o, 0);
        next_cycle();
        ret(1'b0, 2'd0, 5'd0);
        #1;
        chk("drain_credits", credits_o, 32);
        chk("drain_idle", idle_o, 1);

        // All three requesters: ifetch, then load/store alternate
        ifetch_v_i  = 1'b1;
        ld_v_i      = 1'b1;
        st_v_i      = 1'b1;
        ld_reg_id_i = 5'd1;
        #1;
        chk("arb0_sel", out_sel_o, 3'b001);
        chk("arb0_if_ready", ifetch_ready_o, 1);
        next_cycle();
        #1;
        chk("arb1_credits", credits_o, 31);
        chk("arb1_if_pending", ifetch_pending_o, 1);
        chk("arb1_sel", out_sel_o, 3'b010);
        next_cycle();
        ld_reg_id_i = 5'd2;
        #1;
        chk("arb2_credits", credits_o, 30);
        chk("arb2_sel", out_sel_o, 3'b100);
        next_cycle();
        #1;
        chk("arb3_credits", credits_o, 29);
        chk("arb3_sel", out_sel_o, 3'b010);
        next_cycle();
        #1;
        chk("arb4_credits", credits_o, 28);
        chk("arb4_sel", out_sel_o, 3'b100);
        next_cycle();
        ifetch_v_i = 1'b0;
        ld_v_i     = 1'b0;
        st_v_i     = 1'b0;
        ret(1'b1, 2'd2, 5'd0);
        #1;
        chk("arb5_credits", credits_o, 27);
        chk("arb5_int_pending", int_pending_o, 32'h6);
        next_cycle();
        ret(1'b0, 2'd0, 5'd0);
        #1;
        chk("if_ret_clear", ifetch_pending_o, 0);
        chk("if_ret_credits", credits_o, 28);

        // Reset with 4 outstanding requests; outputs held quiet during reset
        reset_n_i = 1'b0;
        st_v_i    = 1'b1;
        ret(1'b1, 2'd3, 5'd0);
        #1;
        chk("mid_rst_out_v", out_v_o, 0);
        chk("mid_rst_st_ready", st_ready_o, 0);
        chk("mid_rst_yumi", returned_yumi_o, 0);
        next_cycle();
        reset_n_i = 1'b1;
        ret(1'b0, 2'd0, 5'd0);
        #1;
        chk("mid_rst_credits", credits_o, 32);
        chk("mid_rst_int", int_pending_o, 0);
        chk("mid_rst_idle", idle_o, 1);
        chk("mid_rst_error", error_o, 0);

        // Exhaust all credits with stores
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("st_burst%0d", i), st_ready_o, 1);
            next_cycle();
            #1;
        end
        chk("exh_credits", credits_o, 0);
        chk("exh_out_v", out_v_o, 0);
        ret(1'b1, 2'd3, 5'd0);
        #1;
        chk("exh_ret_no_bypass", out_v_o, 0);
        next_cycle();
        ret(1'b0, 2'd0, 5'd0);
        #1;
        chk("exh_one_credit", credits_o, 1);
        chk("exh_one_issue", st_ready_o, 1);
        next_cycle();
        st_v_i = 1'b0;
        #1;
        chk("exh_zero_again", credits_o, 0);
        for (int i = 0; i < 3; i++) begin
            ret(1'b1, 2'd3, 5'd0);
            next_cycle();
        end
        ret(1'b0, 2'd0, 5'd0);
        #1;
        chk("cr3_credits", credits_o, 3);

        // Simultaneous issue and return at credits 3
        st_v_i = 1'b1;
        ret(1'b1, 2'd3, 5'd0);
        #1;
        chk("cr3_st_ready", st_ready_o, 1);
        next_cycle();
        st_v_i = 1'b0;
        ret(1'b1, 2'd1, 5'd7);
        #1;
        chk("cr3_hold", credits_o, 3);
        chk("cr3_no_error", error_o, 0);
        next_cycle();
        ret(1'b0, 2'd0, 5'd0);
        #1;
        chk("bad_ret_error", error_o, 1);
        chk("bad_ret_float7", float_pending_o[7], 0);
        chk("bad_ret_credits", credits_o, 4);
        next_cycle();
        #1;
        chk("error_sticky", error_o, 1);

        // Int load to reg 0 tracks nothing; float reg 0 is a real register
        ld_v_i      = 1'b1;
        ld_float_i  = 1'b0;
        ld_reg_id_i = 5'd0;
        #1;
        chk("ld_r0_ready", ld_ready_o, 1);
        next_cycle();
        ld_v_i = 1'b0;
        #1;
        chk("ld_r0_int", int_pending_o, 0);
        chk("ld_r0_credits", credits_o, 3);
        ld_v_i     = 1'b1;
        ld_float_i = 1'b1;
        #1;
        chk("fld_r0_ready", ld_ready_o, 1);
        next_cycle();
        ld_v_i = 1'b0;
        #1;
        chk("fld_r0_float", float_pending_o, 32'h1);
        chk("fld_r0_credits", credits_o, 2);

        // Reset clears error; a return with nothing outstanding sets it, credits saturate
        reset_n_i = 1'b0;
        next_cycle();
        reset_n_i = 1'b1;
        #1;
        chk("rst2_error", error_o, 0);
        chk("rst2_credits", credits_o, 32);
        chk("rst2_float", float_pending_o, 0);
        ret(1'b1, 2'd3, 5'd0);
        next_cycle();
        ret(1'b0, 2'd0, 5'd0);
        #1;
        chk("over_ret_error", error_o, 1);
        chk("over_ret_sat", credits_o, 32);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/remote_req_sched.md
Name: remote_req_sched

Overview:
- Issue scheduler for the tile's outgoing remote-request port, sitting between the vanilla core/icache request sources and network_tx.
- Arbitrates three requesters (icache fetch, remote load, remote store) onto one outgoing packet slot.
- Enforces an outstanding-request credit limit and a per-register pending scoreboard for int and float remote loads.
- Retires responses from the return path, and reports idle/fence status plus sticky protocol errors.

Parameters:
- max_out_credits_p, 32, max outstanding remote requests (all types).
- num_reg_p, 32, registers per file (int and float).
- reg_id_width_lp, clog2(num_reg_p), register id width.
- credit_width_lp, clog2(max_out_credits_p+1), credit counter width.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  reset.
- ifetch_v_i  in  1  icache fetch request valid.
- ifetch_ready_o  out  1  icache fetch issued this cycle.
- ld_v_i  in  1  remote load request valid (int load or amo).
- ld_float_i  in  1  load writes back to the float file.
- ld_reg_id_i  in  reg_id_width_lp  destination register.
- ld_ready_o  out  1  load issued this cycle.
- st_v_i  in  1  remote store request valid.
- st_ready_o  out  1  store issued this cycle.
- out_v_o  out  1  a request is presented to network_tx.
- out_sel_o  out  3  one-hot source select {store, load, ifetch}.
- out_ready_i  in  1  network_tx accepts the packet.
- returned_v_i  in  1  response valid.
- returned_type_i  in  2  0=int_wb, 1=float_wb, 2=ifetch, 3=store ack.
- returned_reg_id_i  in  reg_id_width_lp  response register id.
- returned_yumi_o  out  1  response consumed.
- credits_o  out  credit_width_lp  available credits.
- int_pending_o  out  num_reg_p  int scoreboard.
- float_pending_o  out  num_reg_p  float scoreboard.
- ifetch_pending_o  out  1  icache fetch outstanding.
- idle_o  out  1  nothing outstanding.
- error_o  out  1  sticky protocol error.

Behaviour:
- Reset: one clock; reset is synchronous and active-low (reset_n_i).
  - While reset_n_i=0, at each clk_i edge: credits ← max_out_credits_p; all pending bits ← 0; error_o ← 0; round-robin pointer ← load-first.
  - Outputs during reset: out_v_o=0, all *_ready_o=0, returned_yumi_o=0.
  - Reset mid-operation discards all outstanding state with no drain.
- Eligibility, evaluated on registered state only (no same-cycle bypass of returns into hazard checks):
  - ifetch eligible = ifetch_v_i & ~ifetch_pending & credits>0.
  - load eligible = ld_v_i & credits>0 & ~pending[file][ld_reg_id_i].
  - store eligible = st_v_i & credits>0.
- Arbitration:
  - ifetch has fixed highest priority.
  - Load and store share a 2-way round-robin; the pointer flips to the other source only when the current winner issues.
  - out_v_o = any eligible; out_sel_o = winner, one-hot; out_sel_o=0 when out_v_o=0.
- Issue:
  - Issue = out_v_o & out_ready_i.
  - The winner's *_ready_o = issue; all other *_ready_o = 0.
  - Combinational, zero latency.
- Credits:
  - −1 on issue; +1 on returned_v_i & returned_yumi_o (any type).
  - Simultaneous issue and return leaves credits unchanged.
  - A return at credits==max_out_credits_p sets error_o; the counter saturates (no wrap).
- Scoreboard:
  - Load issue sets pending[ld_float_i ? float : int][reg]. An int load to reg 0 sets nothing.
  - Ifetch issue sets ifetch_pending.
  - Return of type 0/1/2 clears the matching bit next edge. Type 3 touches no bit.
  - A return for a bit not set (int reg 0 included) sets error_o; the bit stays 0.
  - Same-cycle issue of reg R and return of R: not possible, since issue requires R clear.
  - Same-cycle issue of R and return of a different reg: both take effect.
- returned_yumi_o = returned_v_i, always accepted in the same cycle.
- idle_o = (credits==max_out_credits_p) & no pending bits (registered state).
- error_o clears only on reset.

Test Plan:
- Reset, then ld_v_i=1, reg 5, int, out_ready_i=1 → out_sel_o=3'b010, ld_ready_o=1; next cycle credits_o=31, int_pending_o[5]=1, idle_o=0.
- Second int load to reg 5 while pending → out_v_o=0. Return type 0 reg 5 → returned_yumi_o=1, bit clears next cycle, load issues the cycle after.
- ifetch_v_i, ld_v_i, st_v_i all held high with ready=1 → ifetch issues first. Ifetch then blocked (pending) → load, store, load, store alternate; credits drop by 1 per cycle.
- 32 stores issued with no returns → credits_o=0, out_v_o=0 with requests held. One type-3 return → credits_o=1, one store issues.
- At credits_o=3, issue and return in the same cycle → credits_o stays 3. Return type 1 reg 7 with float_pending_o[7]=0 → error_o=1 and stays set.
- Assert reset_n_i=0 with 4 outstanding requests → next edge credits_o=32, all pending=0, idle_o=1, error_o=0.
